// File: rtl/axi_rdata_buffer_if.sv
// Beat bus for axi_rdata_buffer: upstream beat in, head beat out, occupancy flags.
// slave = the buffer, master = the environment driving beats and consuming the head.
interface axi_rdata_buffer_if #(
  parameter int MASTERS    = 4,
  parameter int ID_BITS    = 2,
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [MASTERS-1:0]    master_oh;
  logic [ID_BITS-1:0]    id;
  logic [DATA_WIDTH-1:0] data;
  logic [1:0]            resp;
  logic                  last;
  logic                  valid;
  logic                  ready;

  logic [MASTERS-1:0]    o_master;
  logic [ID_BITS-1:0]    o_id;
  logic [DATA_WIDTH-1:0] o_data;
  logic [1:0]            o_resp;
  logic                  o_last;
  logic                  o_valid;
  logic                  o_ready;

  logic [CNT_W-1:0]      count;
  logic                  almost_full;

  modport slave (
    input  master_oh, id, data, resp, last, valid, o_ready,
    output ready, o_master, o_id, o_data, o_resp, o_last, o_valid, count, almost_full
  );

  modport master (
    output master_oh, id, data, resp, last, valid, o_ready,
    input  ready, o_master, o_id, o_data, o_resp, o_last, o_valid, count, almost_full
  );
endinterface

// File: rtl/axi_rdata_buffer.sv
// AXI read-data return buffer: DEPTH-entry circular FIFO of routed beats, optional packet mode.
// Define AXI_RDATA_BUFFER_STATS_EN to add beat/burst pop counters with synchronous clear.
module axi_rdata_buffer #(
  parameter int MASTERS     = 4,
  parameter int ID_BITS     = 2,
  parameter int DATA_WIDTH  = 512,
  parameter int DEPTH       = 8,
  parameter int AF_MARGIN   = 2,
  parameter int PACKET_MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  axi_rdata_buffer_if.slave  bus
`ifdef AXI_RDATA_BUFFER_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [31:0]        stat_beats,
  output logic [31:0]        stat_bursts
`endif
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AF_TH = (DEPTH > AF_MARGIN) ? DEPTH - AF_MARGIN : 0;

  typedef struct packed {
    logic [MASTERS-1:0]    master;
    logic [ID_BITS-1:0]    id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } beat_t;

  beat_t            mem [DEPTH];
  beat_t            in_beat, head;
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, bursts;
  logic             full, empty, push, pop, o_valid;

  assign in_beat = '{master: bus.master_oh, id: bus.id, data: bus.data,
                     resp: bus.resp, last: bus.last};

  // Extra wrap bit on each pointer separates full from empty at equal addresses.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;

  // Full override keeps a burst longer than DEPTH moving in packet mode.
  assign o_valid = !empty && ((PACKET_MODE == 0) || (bursts != '0) || full);

  assign push = bus.valid && !full;
  assign pop  = o_valid && bus.o_ready;

  // Empty buffer presents an all-zero payload, which also covers reset.
  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_beat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      bursts <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      case ({push && in_beat.last, pop && head.last})
        2'b10:   bursts <= bursts + CNT_W'(1);
        2'b01:   bursts <= bursts - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.ready       = !full;
  assign bus.o_valid     = o_valid;
  assign bus.o_master    = head.master;
  assign bus.o_id        = head.id;
  assign bus.o_data      = head.data;
  assign bus.o_resp      = head.resp;
  assign bus.o_last      = head.last;
  assign bus.count       = count;
  assign bus.almost_full = (count >= CNT_W'(AF_TH));

`ifdef AXI_RDATA_BUFFER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_beats  <= '0;
      stat_bursts <= '0;
    end else if (stat_clr) begin
      stat_beats  <= '0;
      stat_bursts <= '0;
    end else if (pop) begin
      stat_beats <= stat_beats + 32'd1;
      if (head.last) stat_bursts <= stat_bursts + 32'd1;
    end
  end
`else
  // Statistics counters compiled out; the datapath above is unchanged.
`endif

endmodule

// File: tb/tb_axi_rdata_buffer.sv
// Random + directed bench: cut-through DEPTH=8 and packet-mode DEPTH=4 buffers share one
// stimulus stream, each checked every cycle against a queue-based reference model.
module tb_axi_rdata_buffer;
  localparam int DW = 64;

  typedef struct packed {
    logic [3:0]    m;
    logic [1:0]    id;
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic          l;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  beat_t in_b;
  logic  in_valid, o_ready;
  beat_t obs_ct, obs_pk;

  int n_chk = 0;
  int n_err = 0;

  beat_t q_ct[$];
  beat_t q_pk[$];
  bit    pk_pushed;
  int unsigned sb_beats, sb_bursts;

  always #5 clk = ~clk;

  axi_rdata_buffer_if #(.MASTERS(4), .ID_BITS(2), .DATA_WIDTH(DW), .DEPTH(8)) bus_ct ();
  axi_rdata_buffer_if #(.MASTERS(4), .ID_BITS(2), .DATA_WIDTH(DW), .DEPTH(4)) bus_pk ();

  assign bus_ct.master_oh = in_b.m;  assign bus_pk.master_oh = in_b.m;
  assign bus_ct.id        = in_b.id; assign bus_pk.id        = in_b.id;
  assign bus_ct.data      = in_b.d;  assign bus_pk.data      = in_b.d;
  assign bus_ct.resp      = in_b.r;  assign bus_pk.resp      = in_b.r;
  assign bus_ct.last      = in_b.l;  assign bus_pk.last      = in_b.l;
  assign bus_ct.valid     = in_valid; assign bus_pk.valid    = in_valid;
  assign bus_ct.o_ready   = o_ready;  assign bus_pk.o_ready  = o_ready;

  assign obs_ct = {bus_ct.o_master, bus_ct.o_id, bus_ct.o_data, bus_ct.o_resp, bus_ct.o_last};
  assign obs_pk = {bus_pk.o_master, bus_pk.o_id, bus_pk.o_data, bus_pk.o_resp, bus_pk.o_last};

`ifdef AXI_RDATA_BUFFER_STATS_EN
  logic        stat_clr;
  logic [31:0] ct_beats, ct_bursts, pk_beats, pk_bursts;
`endif

  axi_rdata_buffer #(.MASTERS(4), .ID_BITS(2), .DATA_WIDTH(DW), .DEPTH(8),
                     .AF_MARGIN(2), .PACKET_MODE(0)) u_ct (
    .clk(clk), .rst(rst), .bus(bus_ct)
`ifdef AXI_RDATA_BUFFER_STATS_EN
    , .stat_clr(stat_clr), .stat_beats(ct_beats), .stat_bursts(ct_bursts)
`endif
  );

  axi_rdata_buffer #(.MASTERS(4), .ID_BITS(2), .DATA_WIDTH(DW), .DEPTH(4),
                     .AF_MARGIN(2), .PACKET_MODE(1)) u_pk (
    .clk(clk), .rst(rst), .bus(bus_pk)
`ifdef AXI_RDATA_BUFFER_STATS_EN
    , .stat_clr(stat_clr), .stat_beats(pk_beats), .stat_bursts(pk_bursts)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t rnd_beat(input bit l);
    beat_t b;
    b.m  = 4'b0001 << $urandom_range(0, 3);
    b.id = 2'($urandom);
    b.d  = {$urandom, $urandom};
    b.r  = 2'($urandom);
    b.l  = l;
    return b;
  endfunction

  // Head is offered when anything is stored; packet mode also needs a whole burst or a full buffer.
  function automatic bit exp_ovalid(input beat_t q[$], input int depth, input bit pm);
    bit has_last = 1'b0;
    foreach (q[i]) if (q[i].l) has_last = 1'b1;
    if (q.size() == 0) return 1'b0;
    return !pm || has_last || (q.size() == depth);
  endfunction

  task automatic check_one(input string nm, input beat_t q[$], input int depth, input bit pm,
                           input beat_t obs, input logic ov, input logic rdy,
                           input int cnt, input logic af);
    beat_t eh;
    eh = (q.size() != 0) ? q[0] : '0;
    chk({nm, ".count"},   cnt, q.size());
    chk({nm, ".ready"},   rdy, q.size() < depth);
    chk({nm, ".afull"},   af,  q.size() >= depth - 2);
    chk({nm, ".o_valid"}, ov,  exp_ovalid(q, depth, pm));
    chk({nm, ".payload"}, obs, eh);
  endtask

  task automatic upd(inout beat_t q[$], input int depth, input bit pm,
                     output bit popped, output bit pop_last, output bit pushed);
    bit ov, can;
    ov = exp_ovalid(q, depth, pm);
    can = q.size() < depth;
    popped = 1'b0; pop_last = 1'b0; pushed = 1'b0;
    if (ov && o_ready) begin
      pop_last = q[0].l;
      void'(q.pop_front());
      popped = 1'b1;
    end
    if (in_valid && can) begin
      q.push_back(in_b);
      pushed = 1'b1;
    end
  endtask

  task automatic step();
    bit p, pl, pu;
    @(negedge clk);
    check_one("ct", q_ct, 8, 1'b0, obs_ct, bus_ct.o_valid, bus_ct.ready, int'(bus_ct.count), bus_ct.almost_full);
    check_one("pk", q_pk, 4, 1'b1, obs_pk, bus_pk.o_valid, bus_pk.ready, int'(bus_pk.count), bus_pk.almost_full);
`ifdef AXI_RDATA_BUFFER_STATS_EN
    chk("ct.stat_beats",  ct_beats,  sb_beats);
    chk("ct.stat_bursts", ct_bursts, sb_bursts);
`endif
    @(posedge clk);
    upd(q_ct, 8, 1'b0, p, pl, pu);
`ifdef AXI_RDATA_BUFFER_STATS_EN
    if (stat_clr) begin
      sb_beats = 0; sb_bursts = 0;
    end else if (p) begin
      sb_beats++;
      if (pl) sb_bursts++;
    end
`endif
    upd(q_pk, 4, 1'b1, p, pl, pu);
    pk_pushed = pu;
    #1;
  endtask

  initial begin
    int w;
    in_valid = 1'b0; o_ready = 1'b0; in_b = '0;
    sb_beats = 0; sb_bursts = 0;
`ifdef AXI_RDATA_BUFFER_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Single beat, head held while not accepted
    in_b = '{m: 4'b0010, id: 2'd1, d: 64'hA5, r: 2'd0, l: 1'b1};
    in_valid = 1'b1; step();
    in_valid = 1'b0; step(); step();
    o_ready = 1'b1; repeat (3) step();
    o_ready = 1'b0;

    // Fill past capacity, then pop-only while full, then push+pop
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin in_b = rnd_beat(1'b0); step(); end
    o_ready = 1'b1; step(); step();
    in_b = rnd_beat(1'b1); step();
    in_valid = 1'b0; repeat (12) step();
    o_ready = 1'b0;

    // Packet mode waits for LAST
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin in_b = rnd_beat(i == 3); step(); end
    in_valid = 1'b0; step();
    o_ready = 1'b1; repeat (6) step();

    // Burst longer than DEPTH in packet mode, downstream always ready
    for (int i = 0; i < 6; i++) begin
      in_b = rnd_beat(i == 5); in_valid = 1'b1; w = 0;
      do begin step(); w++; end while (!pk_pushed && w < 20);
      chk("pk.accept", pk_pushed, 1'b1);
    end
    in_valid = 1'b0; repeat (12) step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      o_ready  = $urandom_range(0, 1);
      in_b     = rnd_beat($urandom_range(0, 2) == 0);
`ifdef AXI_RDATA_BUFFER_STATS_EN
      stat_clr = ($urandom_range(0, 49) == 0);
`endif
      step();
    end
`ifdef AXI_RDATA_BUFFER_STATS_EN
    stat_clr = 1'b0;
`endif
    in_valid = 1'b0; o_ready = 1'b1; repeat (12) step();

    // Asynchronous reset with stored beats
    o_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin in_b = rnd_beat(1'b0); step(); end
    in_valid = 1'b0; step();
    #2 rst = 1'b1;
    #1;
    chk("ct.rst_count",   bus_ct.count,   0);
    chk("ct.rst_o_valid", bus_ct.o_valid, 0);
    chk("pk.rst_count",   bus_pk.count,   0);
    q_ct.delete(); q_pk.delete();
    sb_beats = 0; sb_bursts = 0;
    @(posedge clk); #1 rst = 1'b0;
    step();

`ifdef AXI_RDATA_BUFFER_STATS_EN
    // 10 pops including 2 LASTs, then clear
    o_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin in_b = rnd_beat(i == 4 || i == 9); step(); end
    in_valid = 1'b0; repeat (3) step();
    chk("ct.stat_beats10",  ct_beats,  32'd10);
    chk("ct.stat_bursts2",  ct_bursts, 32'd2);
    stat_clr = 1'b1; step();
    stat_clr = 1'b0; step();
    chk("ct.stat_clr", {ct_beats, ct_bursts}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
